// File: rtl/axil_addr_decoder.sv
// AXI-Lite address decoder: one outstanding CPU transaction, decoded to a slave select code and
// replayed on the interconnect port after the select mux settles. Optional slave timeout: DEC_TIMEOUT_EN.
module axil_addr_decoder #(
  parameter logic [31:0] DDR_BASE  = 32'h0000_0000,
  parameter logic [31:0] DDR_MASK  = 32'hC000_0000,
  parameter logic [31:0] SD_BASE   = 32'h4000_0000,
  parameter logic [31:0] PER_MASK  = 32'hFFFF_0000,
  parameter logic [31:0] ETH_BASE  = 32'h4001_0000,
  parameter logic [31:0] UART_BASE = 32'h4002_0000,
  parameter logic [31:0] VGA_BASE  = 32'h4003_0000,
  parameter logic [31:0] PS2_BASE  = 32'h4004_0000,
  parameter int          SETTLE    = 2,
  parameter int          TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  // CPU side
  input  logic [31:0] ARADDR_c,
  input  logic        ARVALID_c,
  output logic        ARREADY_c,
  output logic [31:0] RDATA_c,
  output logic        RRESP_c,
  output logic        RVALID_c,
  input  logic        RREADY_c,
  input  logic [31:0] AWADDR_c,
  input  logic        AWVALID_c,
  output logic        AWREADY_c,
  input  logic [31:0] WDATA_c,
  input  logic [3:0]  WSTRB_c,
  input  logic        WVALID_c,
  output logic        WREADY_c,
  output logic        BRESP_c,
  output logic        BVALID_c,
  input  logic        BREADY_c,
  // interconnect master port
  output logic [31:0] ARADDR_m,
  output logic        ARVALID_m,
  input  logic        ARREADY_m,
  input  logic [31:0] RDATA_m,
  input  logic        RRESP_m,
  input  logic        RVALID_m,
  output logic        RREADY_m,
  output logic [31:0] AWADDR_m,
  output logic        AWVALID_m,
  input  logic        AWREADY_m,
  output logic [31:0] WDATA_m,
  output logic [3:0]  WSTRB_m,
  output logic        WVALID_m,
  input  logic        WREADY_m,
  input  logic        BRESP_m,
  input  logic        BVALID_m,
  output logic        BREADY_m,
  output logic [2:0]  select,
  output logic        busy,
  output logic        timeout,
  output logic [3:0]  state
);

  // Handshakes on every channel: a transfer happens on a rising clk edge where valid and ready
  // are both high; a valid, once raised, stays high with stable payload until that transfer.

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_SETTLE  = 4'd1,
    S_RD_ADDR = 4'd2,
    S_RD_DATA = 4'd3,
    S_RD_RSP  = 4'd4,
    S_WR_REQ  = 4'd5,
    S_WR_WAIT = 4'd6,
    S_WR_RSP  = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  localparam int SETTLE_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  state_t              state_q, state_d;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;
  logic                is_write_q;
  logic [2:0]          select_q;
  logic [SETTLE_W-1:0] settle_cnt;
  logic                settle_done;
  logic [31:0]         rdata_q;
  logic                rresp_q;
  logic                bresp_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                rd_acc;
  logic                wr_acc;
  logic [31:0]         acc_addr;
  logic [3:0]          dec;
  logic                waiting;
  logic                tmo_hit;

  // Returns {hit, select code}; earlier matches win.
  function automatic logic [3:0] decode(input logic [31:0] a);
    if ((a & DDR_MASK) == DDR_BASE)       return 4'b1_000;
    else if ((a & PER_MASK) == SD_BASE)   return 4'b1_010;
    else if ((a & PER_MASK) == ETH_BASE)  return 4'b1_011;
    else if ((a & PER_MASK) == UART_BASE) return 4'b1_100;
    else if ((a & PER_MASK) == VGA_BASE)  return 4'b1_101;
    else if ((a & PER_MASK) == PS2_BASE)  return 4'b1_110;
    else                                  return 4'b0_000;
  endfunction

  assign rd_acc      = (state_q == S_IDLE) && ARVALID_c;
  assign wr_acc      = (state_q == S_IDLE) && !ARVALID_c && AWVALID_c && WVALID_c;
  assign acc_addr    = rd_acc ? ARADDR_c : AWADDR_c;
  assign dec         = decode(acc_addr);
  assign settle_done = (settle_cnt == SETTLE_W'(SETTLE - 1));
  assign waiting     = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                       (state_q == S_WR_REQ)  || (state_q == S_WR_WAIT);

  assign ARADDR_m = addr_q;
  assign AWADDR_m = addr_q;
  assign WDATA_m  = wdata_q;
  assign WSTRB_m  = wstrb_q;
  assign select   = select_q;
  assign busy     = (state_q != S_IDLE);
  assign state    = state_q;

`ifdef DEC_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Restarts for each forwarded request; saturates so it can never wrap back below the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= 8'd0;
    end else if (state_q == S_SETTLE) begin
      tmo_cnt <= 8'd0;
    end else if (waiting && tmo_cnt != 8'hFF) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end

  assign tmo_hit = waiting && (tmo_cnt == 8'(TIMEOUT));
`else
  logic timeout_unused;
  assign timeout_unused = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ARREADY_c = 1'b0;
    AWREADY_c = 1'b0;
    WREADY_c  = 1'b0;
    RVALID_c  = 1'b0;
    RDATA_c   = 32'h0;
    RRESP_c   = 1'b0;
    BVALID_c  = 1'b0;
    BRESP_c   = 1'b0;
    ARVALID_m = 1'b0;
    RREADY_m  = 1'b0;
    AWVALID_m = 1'b0;
    WVALID_m  = 1'b0;
    BREADY_m  = 1'b0;
    timeout   = 1'b0;
    case (state_q)
      S_IDLE: begin
        ARREADY_c = rd_acc;
        AWREADY_c = wr_acc;
        WREADY_c  = wr_acc;
        if (rd_acc || wr_acc) state_d = dec[3] ? S_SETTLE : S_ERR;
      end
      S_SETTLE: begin
        if (settle_done) state_d = is_write_q ? S_WR_REQ : S_RD_ADDR;
      end
      S_RD_ADDR: begin
        ARVALID_m = 1'b1;
        if (ARREADY_m) begin
          state_d = S_RD_DATA;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          timeout = 1'b1;
        end
      end
      S_RD_DATA: begin
        RREADY_m = 1'b1;
        if (RVALID_m) begin
          state_d = S_RD_RSP;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          timeout = 1'b1;
        end
      end
      S_RD_RSP: begin
        RVALID_c = 1'b1;
        RDATA_c  = rdata_q;
        RRESP_c  = rresp_q;
        if (RREADY_c) state_d = S_IDLE;
      end
      S_WR_REQ: begin
        AWVALID_m = !aw_done_q;
        WVALID_m  = !w_done_q;
        if ((aw_done_q || AWREADY_m) && (w_done_q || WREADY_m)) begin
          state_d = S_WR_WAIT;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          timeout = 1'b1;
        end
      end
      S_WR_WAIT: begin
        BREADY_m = 1'b1;
        if (BVALID_m) begin
          state_d = S_WR_RSP;
        end else if (tmo_hit) begin
          state_d = S_ERR;
          timeout = 1'b1;
        end
      end
      S_WR_RSP: begin
        BVALID_c = 1'b1;
        BRESP_c  = bresp_q;
        if (BREADY_c) state_d = S_IDLE;
      end
      S_ERR: begin
        // Local error response; the interconnect port stays quiet.
        if (is_write_q) begin
          BVALID_c = 1'b1;
          BRESP_c  = 1'b1;
          if (BREADY_c) state_d = S_IDLE;
        end else begin
          RVALID_c = 1'b1;
          RRESP_c  = 1'b1;
          if (RREADY_c) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
      is_write_q <= 1'b0;
      select_q   <= 3'b000;
      settle_cnt <= '0;
      rdata_q    <= 32'h0;
      rresp_q    <= 1'b0;
      bresp_q    <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (rd_acc || wr_acc) begin
        addr_q     <= acc_addr;
        is_write_q <= wr_acc;
        settle_cnt <= '0;
        if (wr_acc) begin
          wdata_q <= WDATA_c;
          wstrb_q <= WSTRB_c;
        end
        // A miss leaves the mux where it was.
        if (dec[3]) select_q <= dec[2:0];
      end
      if (state_q == S_SETTLE) begin
        aw_done_q <= 1'b0;
        w_done_q  <= 1'b0;
        if (!settle_done) settle_cnt <= settle_cnt + SETTLE_W'(1);
      end
      if (state_q == S_WR_REQ) begin
        if (AWVALID_m && AWREADY_m) aw_done_q <= 1'b1;
        if (WVALID_m && WREADY_m)   w_done_q  <= 1'b1;
      end
      if (state_q == S_RD_DATA && RVALID_m) begin
        rdata_q <= RDATA_m;
        rresp_q <= RRESP_m;
      end
      if (state_q == S_WR_WAIT && BVALID_m) bresp_q <= BRESP_m;
    end
  end

endmodule

// File: tb/tb_axil_addr_decoder.sv
// Directed bench for axil_addr_decoder: vector table of single transactions plus hand sequences
// for arbitration, partial write requests, independent AW/W completion, reset and slave timeout.
module tb_axil_addr_decoder;

  localparam int SETTLE = 2;

  logic        clk, rst_n;
  logic [31:0] ARADDR_c, RDATA_c, AWADDR_c, WDATA_c;
  logic        ARVALID_c, ARREADY_c, RRESP_c, RVALID_c, RREADY_c;
  logic        AWVALID_c, AWREADY_c, WVALID_c, WREADY_c, BRESP_c, BVALID_c, BREADY_c;
  logic [3:0]  WSTRB_c, WSTRB_m, state;
  logic [31:0] ARADDR_m, RDATA_m, AWADDR_m, WDATA_m;
  logic        ARVALID_m, ARREADY_m, RRESP_m, RVALID_m, RREADY_m;
  logic        AWVALID_m, AWREADY_m, WVALID_m, WREADY_m, BRESP_m, BVALID_m, BREADY_m;
  logic [2:0]  select;
  logic        busy, timeout;

  axil_addr_decoder #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n),
    .ARADDR_c(ARADDR_c), .ARVALID_c(ARVALID_c), .ARREADY_c(ARREADY_c),
    .RDATA_c(RDATA_c), .RRESP_c(RRESP_c), .RVALID_c(RVALID_c), .RREADY_c(RREADY_c),
    .AWADDR_c(AWADDR_c), .AWVALID_c(AWVALID_c), .AWREADY_c(AWREADY_c),
    .WDATA_c(WDATA_c), .WSTRB_c(WSTRB_c), .WVALID_c(WVALID_c), .WREADY_c(WREADY_c),
    .BRESP_c(BRESP_c), .BVALID_c(BVALID_c), .BREADY_c(BREADY_c),
    .ARADDR_m(ARADDR_m), .ARVALID_m(ARVALID_m), .ARREADY_m(ARREADY_m),
    .RDATA_m(RDATA_m), .RRESP_m(RRESP_m), .RVALID_m(RVALID_m), .RREADY_m(RREADY_m),
    .AWADDR_m(AWADDR_m), .AWVALID_m(AWVALID_m), .AWREADY_m(AWREADY_m),
    .WDATA_m(WDATA_m), .WSTRB_m(WSTRB_m), .WVALID_m(WVALID_m), .WREADY_m(WREADY_m),
    .BRESP_m(BRESP_m), .BVALID_m(BVALID_m), .BREADY_m(BREADY_m),
    .select(select), .busy(busy), .timeout(timeout), .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] sdata;
    logic        sresp;
    logic [2:0]  sel;
    logic        hit;
    logic [31:0] edata;
    logic        eresp;
  } vec_t;

  vec_t vec [10];

  // slave / CPU model controls and monitor captures
  int          cyc = 0;
  int          acc_cyc;
  logic        hold_r;
  int          aw_stall;
  logic [31:0] s_rdata;
  logic        s_resp;
  logic        ar_seen, aw_seen, r_seen, b_seen, tmo_seen, w_early, aw_unstable;
  int          ar_cyc, tmo_cyc;
  logic [31:0] ar_addr, aw_addr, w_data, r_data;
  logic [3:0]  w_strb;
  logic [2:0]  ar_sel, sel_acc;
  logic        r_resp, b_resp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_mon();
    ar_seen = 0; aw_seen = 0; r_seen = 0; b_seen = 0; tmo_seen = 0;
    w_early = 0; aw_unstable = 0; acc_cyc = -10; ar_cyc = 0; tmo_cyc = 0;
    sel_acc = 3'b111;
  endtask

  // One cycle: sample at the falling edge, then drive slave and CPU responses for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (cyc == acc_cyc + 1) sel_acc = select;
    if (ARVALID_m && !ar_seen) begin
      ar_seen = 1; ar_cyc = cyc; ar_addr = ARADDR_m; ar_sel = select;
    end
    if (AWVALID_m && !aw_seen) begin
      aw_seen = 1; aw_addr = AWADDR_m; w_data = WDATA_m; w_strb = WSTRB_m;
    end
    if (AWVALID_m && aw_seen && AWADDR_m !== aw_addr) aw_unstable = 1;
    if (AWVALID_m && !WVALID_m) w_early = 1;
    if (RVALID_c && !r_seen) begin
      r_seen = 1; r_data = RDATA_c; r_resp = RRESP_c;
    end
    if (BVALID_c && !b_seen) begin
      b_seen = 1; b_resp = BRESP_c;
    end
    if (timeout && !tmo_seen) begin
      tmo_seen = 1; tmo_cyc = cyc;
    end
    ARREADY_m = ARVALID_m;
    if (AWVALID_m && aw_stall > 0) begin
      AWREADY_m = 1'b0;
      aw_stall--;
    end else begin
      AWREADY_m = AWVALID_m;
    end
    WREADY_m  = WVALID_m;
    RVALID_m  = RREADY_m && !hold_r;
    RDATA_m   = s_rdata;
    RRESP_m   = s_resp;
    BVALID_m  = BREADY_m;
    BRESP_m   = s_resp;
    RREADY_c  = RVALID_c;
    BREADY_c  = BVALID_c;
  endtask

  // Present one request in IDLE; it must be taken in the same cycle.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb);
    if (wr) begin
      AWADDR_c = addr; WDATA_c = wdata; WSTRB_c = wstrb; AWVALID_c = 1; WVALID_c = 1;
    end else begin
      ARADDR_c = addr; ARVALID_c = 1;
    end
    #1;
    chk(wr ? "accept_wr" : "accept_rd", wr ? {AWREADY_c, WREADY_c} : {1'b0, ARREADY_c},
        wr ? 2'b11 : 2'b01);
    acc_cyc = cyc;
    tick();
    ARVALID_c = 0; AWVALID_c = 0; WVALID_c = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!(r_seen || b_seen) && n < budget) begin
      tick();
      n++;
    end
    chk("rsp_seen", {31'b0, r_seen | b_seen}, 32'd1);
    if (!(r_seen || b_seen)) begin
      do_reset();
    end else begin
      tick();
      chk("back_idle", {29'b0, RVALID_c, BVALID_c, busy}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 0; hold_r = 0; aw_stall = 0; s_rdata = 0; s_resp = 0;
    ARADDR_c = 0; ARVALID_c = 0; RREADY_c = 0; AWADDR_c = 0; AWVALID_c = 0;
    WDATA_c = 0; WSTRB_c = 0; WVALID_c = 0; BREADY_c = 0;
    ARREADY_m = 0; RDATA_m = 0; RRESP_m = 0; RVALID_m = 0;
    AWREADY_m = 0; WREADY_m = 0; BRESP_m = 0; BVALID_m = 0;
    clear_mon();

    vec[0] = '{0, 32'h4002_0004, 32'h0, 4'h0, 32'h1234_5678, 0, 3'b100, 1, 32'h1234_5678, 0};
    vec[1] = '{0, 32'h8000_0000, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, 3'b100, 0, 32'h0000_0000, 1};
    vec[2] = '{1, 32'h0000_0100, 32'hCAFE_F00D, 4'hF, 32'h0, 0, 3'b000, 1, 32'h0, 0};
    vec[3] = '{0, 32'h4001_0010, 32'h0, 4'h0, 32'hDEAD_BEEF, 1, 3'b011, 1, 32'hDEAD_BEEF, 1};
    vec[4] = '{1, 32'h4003_00FC, 32'h0000_00A5, 4'h1, 32'h0, 1, 3'b101, 1, 32'h0, 1};
    vec[5] = '{1, 32'h4005_0000, 32'h1111_1111, 4'hF, 32'h0, 0, 3'b101, 0, 32'h0, 1};
    vec[6] = '{0, 32'h4004_0000, 32'h0, 4'h0, 32'h0BAD_F00D, 0, 3'b110, 1, 32'h0BAD_F00D, 0};
    vec[7] = '{0, 32'h4000_FFFC, 32'h0, 4'h0, 32'h00C0_FFEE, 0, 3'b010, 1, 32'h00C0_FFEE, 0};
    vec[8] = '{0, 32'h3FFF_FFFC, 32'h0, 4'h0, 32'h1111_2222, 0, 3'b000, 1, 32'h1111_2222, 0};
    vec[9] = '{1, 32'hC000_0000, 32'h2222_2222, 4'hF, 32'h0, 0, 3'b000, 0, 32'h0, 1};

    // reset state
    tick();
    tick();
    chk("rst_cpu", {23'b0, ARREADY_c, RVALID_c, RRESP_c, AWREADY_c, WREADY_c, BVALID_c, BRESP_c,
                    busy, timeout}, 32'd0);
    chk("rst_m_ctl", {27'b0, ARVALID_m, RREADY_m, AWVALID_m, WVALID_m, BREADY_m}, 32'd0);
    chk("rst_sel", {29'b0, select}, 32'd0);
    chk("rst_data", RDATA_c | ARADDR_m | AWADDR_m | WDATA_m | {28'b0, WSTRB_m}, 32'd0);
    rst_n = 1;
    tick();

    // vector table
    for (int i = 0; i < 10; i++) begin
      clear_mon();
      s_rdata = vec[i].sdata;
      s_resp  = vec[i].sresp;
      issue(vec[i].wr, vec[i].addr, vec[i].wdata, vec[i].wstrb);
      wait_done(40);
      chk($sformatf("v%0d_sel", i), {29'b0, sel_acc}, {29'b0, vec[i].sel});
      chk($sformatf("v%0d_m_valid", i), {31'b0, ar_seen | aw_seen}, {31'b0, vec[i].hit});
      if (vec[i].wr) begin
        chk($sformatf("v%0d_bresp", i), {31'b0, b_resp}, {31'b0, vec[i].eresp});
        if (vec[i].hit) begin
          chk($sformatf("v%0d_awaddr", i), aw_addr, vec[i].addr);
          chk($sformatf("v%0d_wdata", i), w_data, vec[i].wdata);
          chk($sformatf("v%0d_wstrb", i), {28'b0, w_strb}, {28'b0, vec[i].wstrb});
        end
      end else begin
        chk($sformatf("v%0d_rdata", i), r_data, vec[i].edata);
        chk($sformatf("v%0d_rresp", i), {31'b0, r_resp}, {31'b0, vec[i].eresp});
        if (vec[i].hit) begin
          chk($sformatf("v%0d_araddr", i), ar_addr, vec[i].addr);
          chk($sformatf("v%0d_settle", i), ar_cyc - acc_cyc, SETTLE + 1);
          chk($sformatf("v%0d_ar_sel", i), {29'b0, ar_sel}, {29'b0, vec[i].sel});
        end
      end
    end

    // read and full write offered together: read first, write taken on the next IDLE
    clear_mon();
    s_rdata = 32'hA5A5_0001; s_resp = 0;
    ARADDR_c = 32'h4002_0008; ARVALID_c = 1;
    AWADDR_c = 32'h4003_0010; WDATA_c = 32'h5555_AAAA; WSTRB_c = 4'hC;
    AWVALID_c = 1; WVALID_c = 1;
    #1;
    chk("both_ready", {29'b0, ARREADY_c, AWREADY_c, WREADY_c}, 32'b100);
    acc_cyc = cyc;
    tick();
    ARVALID_c = 0;
    #1;
    chk("busy_no_aw", {30'b0, AWREADY_c, WREADY_c}, 32'd0);
    wait_done(40);
    chk("both_rd_first", {29'b0, r_seen, b_seen, aw_seen}, 32'b100);
    chk("both_rdata", r_data, 32'hA5A5_0001);
    clear_mon();
    #1;
    chk("both_wr_ready", {30'b0, AWREADY_c, WREADY_c}, 32'b11);
    acc_cyc = cyc;
    tick();
    AWVALID_c = 0; WVALID_c = 0;
    wait_done(40);
    chk("both_wr_sel", {29'b0, sel_acc}, 32'b101);
    chk("both_wr_data", w_data, 32'h5555_AAAA);
    chk("both_wr_addr", aw_addr, 32'h4003_0010);

    // address without data is not accepted
    AWADDR_c = 32'h4002_0000; AWVALID_c = 1; WVALID_c = 0;
    #1;
    chk("aw_only_rdy", {30'b0, AWREADY_c, WREADY_c}, 32'd0);
    tick();
    tick();
    chk("aw_only_idle", {31'b0, busy}, 32'd0);
    AWVALID_c = 0;
    WVALID_c = 1;
    #1;
    chk("w_only_rdy", {30'b0, AWREADY_c, WREADY_c}, 32'd0);
    WVALID_c = 0;
    tick();

    // slow address channel: data completes first and drops on its own
    clear_mon();
    aw_stall = 3; s_resp = 0;
    issue(1, 32'h4004_0020, 32'h0F0F_0F0F, 4'h3);
    wait_done(40);
    chk("split_w_early", {31'b0, w_early}, 32'd1);
    chk("split_aw_stable", {31'b0, aw_unstable}, 32'd0);
    chk("split_bresp", {31'b0, b_resp}, 32'd0);
    chk("split_data", w_data, 32'h0F0F_0F0F);

    // slave never answers the read
    clear_mon();
    hold_r = 1; s_rdata = 32'h7777_7777;
    issue(0, 32'h4004_0000, 32'h0, 4'h0);
`ifdef DEC_TIMEOUT_EN
    wait_done(400);
    chk("tmo_pulse", {31'b0, tmo_seen}, 32'd1);
    chk("tmo_delay", tmo_cyc - ar_cyc, 32'd255);
    chk("tmo_rresp", {31'b0, r_resp}, 32'd1);
    chk("tmo_rdata", r_data, 32'd0);
    chk("tmo_sel", {29'b0, select}, 32'b110);
    clear_mon();
    issue(0, 32'h4004_0000, 32'h0, 4'h0);
    repeat (5) tick();
`else
    repeat (300) tick();
    chk("no_tmo", {30'b0, tmo_seen, r_seen}, 32'd0);
    chk("hang_busy", {31'b0, busy}, 32'd1);
`endif

    // asynchronous reset while waiting for read data
    chk("in_rd_data", {30'b0, RREADY_m, busy}, 32'b11);
    #2;
    rst_n = 0;
    #1;
    chk("arst_ctl", {26'b0, busy, RREADY_m, ARVALID_m, RVALID_c, BVALID_c, timeout}, 32'd0);
    chk("arst_sel", {29'b0, select}, 32'd0);
    chk("arst_addr", ARADDR_m, 32'd0);
    tick();
    rst_n = 1;
    hold_r = 0;
    tick();

    // normal traffic after reset
    clear_mon();
    s_rdata = 32'h600D_0001; s_resp = 0;
    issue(0, 32'h4001_0000, 32'h0, 4'h0);
    wait_done(40);
    chk("post_rst_sel", {29'b0, sel_acc}, 32'b011);
    chk("post_rst_rdata", r_data, 32'h600D_0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
